// File: rtl/prog_freq_div.sv
// Multi-channel programmable clock divider with per-channel tick pulses.
// A new divisor is held in a shadow register and takes effect only at a period boundary.
module prog_freq_div #(
  parameter  int unsigned NCH     = 4,
  parameter  int unsigned CW      = 16,
  parameter  int unsigned DEF_DIV = 2,
  localparam int unsigned CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           sync_rst,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  output logic [NCH-1:0] cfg_pending,
  output logic [NCH-1:0] div_out,
  output logic [NCH-1:0] tick
);

  localparam logic [CW-1:0] One    = CW'(1);
  localparam logic [CW-1:0] DefDiv = CW'(DEF_DIV);
  localparam logic [CW-1:0] DefCnt = (DEF_DIV == 0) ? '0 : CW'(DEF_DIV - 1);

  logic [CW-1:0]  cnt_q  [NCH];
  logic [CW-1:0]  cnt_d  [NCH];
  logic [CW-1:0]  act_q  [NCH];
  logic [CW-1:0]  act_d  [NCH];
  logic [CW-1:0]  pend_q [NCH];
  logic [CW-1:0]  pend_d [NCH];
  logic [NCH-1:0] pv_q, pv_d;
  logic [NCH-1:0] div_q, div_d;
  logic [NCH-1:0] tick_q, tick_d;

  always_comb begin
    logic          wr;
    logic          pv_nx;
    logic          wrap;
    logic [CW-1:0] pend_nx;
    pv_d   = pv_q;
    div_d  = div_q;
    tick_d = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]  = cnt_q[i];
      act_d[i]  = act_q[i];
      // Selects beyond NCH-1 never match any channel, so such writes are dropped.
      wr        = cfg_we && (cfg_ch == CHW'(i));
      pend_nx   = wr ? cfg_div : pend_q[i];
      pv_nx     = wr | pv_q[i];
      pend_d[i] = pend_nx;
      pv_d[i]   = pv_nx;
      wrap      = (act_q[i] != '0) && (cnt_q[i] == act_q[i] - One);

      if (sync_rst) begin
        act_d[i]  = pv_nx ? pend_nx : act_q[i];
        pv_d[i]   = 1'b0;
        cnt_d[i]  = '0;
        div_d[i]  = act_d[i] > One;
        tick_d[i] = act_d[i] != '0;
      end else if (act_q[i] == '0) begin
        // A disabled channel picks up a new divisor straight away, even while frozen.
        if (pv_nx) begin
          act_d[i] = pend_nx;
          pv_d[i]  = 1'b0;
        end
        cnt_d[i]  = '0;
        div_d[i]  = act_d[i] > One;
        tick_d[i] = en && (act_d[i] != '0);
      end else if (en) begin
        if (wrap) begin
          act_d[i] = pv_nx ? pend_nx : act_q[i];
          pv_d[i]  = 1'b0;
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + One;
        end
        div_d[i]  = cnt_d[i] < (act_d[i] >> 1);
        tick_d[i] = wrap && (act_d[i] != '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= DefCnt;
        act_q[i]  <= DefDiv;
        pend_q[i] <= DefDiv;
      end
      pv_q   <= '0;
      div_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        act_q[i]  <= act_d[i];
        pend_q[i] <= pend_d[i];
      end
      pv_q   <= pv_d;
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign cfg_pending = pv_q;
  assign div_out     = div_q;
  assign tick        = tick_q;

endmodule
